// File: rtl/mtm_alu_pkg.sv
// Shared types, field indices, framing constants and CRC helpers for the mtm_alu serial ALU.
package mtm_alu_pkg;

  localparam int FRAME_LEN  = 11;
  localparam int MAX_FRAMES = 5;
  localparam int PKT_BITS   = FRAME_LEN * MAX_FRAMES;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_t;

  localparam int FLAG_CARRY = 3;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_NEG   = 0;

  localparam int ERR_DATA = 2;
  localparam int ERR_CRC  = 1;
  localparam int ERR_OP   = 0;

  // Error CTL payload: {1, ED, EC, EO, ED, EC, EO, even parity of the first seven bits}.
  function automatic logic [7:0] err_payload(input logic [2:0] err);
    logic [6:0] body;
    body = {1'b1, err, err};
    return {body, ^body};
  endfunction

  function automatic logic [3:0] crc4(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  function automatic logic [2:0] crc3(input logic [36:0] d);
    logic [2:0] c;
    logic       fb;
    c = '0;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c  = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
    end
    return c;
  endfunction

endpackage

// File: rtl/mtm_alu_serializer.sv
// Shifts out up to five queued 11-bit frames back to back on sout_o; holds the line high when idle.
module mtm_alu_serializer
  import mtm_alu_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_i,
  input  logic [MAX_FRAMES-1:0][8:0]  frames_i,
  input  logic [2:0]                  nframes_i,
  output logic                        busy_o,
  output logic                        sout_o
);

  logic [PKT_BITS-1:0] pkt_bits;
  logic [PKT_BITS-1:0] shift_q, shift_d;
  logic [5:0]          cnt_q, cnt_d;
  logic                sout_q, sout_d;

  // NOTE: every variable is given a default first so no path through this block infers a latch.
  always_comb begin
    pkt_bits = '1;
    for (int i = 0; i < MAX_FRAMES; i++) begin
      pkt_bits[PKT_BITS-1-FRAME_LEN*i -: FRAME_LEN] = {1'b0, frames_i[i], 1'b1};
    end

    shift_d = shift_q;
    cnt_d   = cnt_q;
    sout_d  = 1'b1;
    if (load_i) begin
      sout_d  = pkt_bits[PKT_BITS-1];
      shift_d = {pkt_bits[PKT_BITS-2:0], 1'b1};
      cnt_d   = 6'(int'(nframes_i) * FRAME_LEN - 1);
    end else if (cnt_q != 6'd0) begin
      sout_d  = shift_q[PKT_BITS-1];
      shift_d = {shift_q[PKT_BITS-2:0], 1'b1};
      cnt_d   = cnt_q - 6'd1;
    end
  end

  // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '1;
      cnt_q   <= '0;
      sout_q  <= 1'b1;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
    end
  end

  assign busy_o = (cnt_q != 6'd0);
  assign sout_o = sout_q;

endmodule

// File: rtl/mtm_alu.sv
// mtm_alu: serial 32-bit ALU -- frame receiver, packet checker, ALU and response queue.
// Define MTM_ALU_SIN_SYNC_EN to pass sin through a 2-flop synchronizer (adds 2 cycles of latency).
module mtm_alu
  import mtm_alu_pkg::*;
#(
  parameter int OUT_GAP = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sin,
  output logic sout
);

  typedef enum logic {RX_IDLE, RX_BITS} rx_state_t;

  localparam logic [7:0] GAP_INIT = 8'(OUT_GAP - 1);

  logic sin_s;

`ifdef MTM_ALU_SIN_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], sin};
  end
  assign sin_s = sync_q[1];
`else
  assign sin_s = sin;
`endif

  rx_state_t                       rx_state_q, rx_state_d;
  logic [3:0]                      bit_cnt_q, bit_cnt_d;
  logic [8:0]                      rx_q, rx_d;
  logic [63:0]                     data_q, data_d;
  logic [3:0]                      dcnt_q, dcnt_d;
  logic                            derr_q, derr_d;
  logic                            resp_valid_q, resp_valid_d;
  logic [7:0]                      resp_gap_q, resp_gap_d;
  logic [MAX_FRAMES-1:0][8:0]      resp_frames_q, resp_frames_d;
  logic [2:0]                      resp_n_q, resp_n_d;

  logic                            ser_load, ser_busy;
  logic [31:0]                     op_b, op_a, alu_c;
  logic [2:0]                      op_raw;
  logic                            op_valid;
  logic [32:0]                     sum, dif;
  logic [3:0]                      flags;
  logic [2:0]                      err;
  logic [MAX_FRAMES-1:0][8:0]      cmd_frames;
  logic [2:0]                      cmd_n;

  assign op_b   = data_q[63:32];
  assign op_a   = data_q[31:0];
  assign op_raw = rx_q[6:4];

  // Response for the CMD frame currently held in rx_q; only consumed on its stop bit.
  always_comb begin
    sum      = {1'b0, op_b} + {1'b0, op_a};
    dif      = {1'b0, op_b} - {1'b0, op_a};
    op_valid = op_raw inside {OP_AND, OP_OR, OP_ADD, OP_SUB};
    alu_c    = '0;
    flags    = '0;
    case (op_raw)
      OP_AND: alu_c = op_b & op_a;
      OP_OR:  alu_c = op_b | op_a;
      OP_ADD: begin
        alu_c             = sum[31:0];
        flags[FLAG_CARRY] = sum[32];
        flags[FLAG_OVF]   = (op_b[31] == op_a[31]) && (sum[31] != op_b[31]);
      end
      OP_SUB: begin
        alu_c             = dif[31:0];
        flags[FLAG_CARRY] = dif[32];
        flags[FLAG_OVF]   = (op_b[31] != op_a[31]) && (dif[31] != op_b[31]);
      end
      default: ;
    endcase
    flags[FLAG_ZERO] = (alu_c == 32'd0);
    flags[FLAG_NEG]  = alu_c[31];

    err = '0;
    if (derr_q || dcnt_q != 4'd8)                        err[ERR_DATA] = 1'b1;
    else if (crc4({op_b, op_a, 1'b1, op_raw}) != rx_q[3:0]) err[ERR_CRC]  = 1'b1;
    else if (!op_valid)                                  err[ERR_OP]   = 1'b1;

    cmd_frames = '0;
    if (err != 3'b000) begin
      cmd_frames[0] = {1'b1, err_payload(err)};
      cmd_n         = 3'd1;
    end else begin
      cmd_frames[0] = {1'b0, alu_c[31:24]};
      cmd_frames[1] = {1'b0, alu_c[23:16]};
      cmd_frames[2] = {1'b0, alu_c[15:8]};
      cmd_frames[3] = {1'b0, alu_c[7:0]};
      cmd_frames[4] = {1'b1, 1'b0, flags, crc3({alu_c, 1'b0, flags})};
      cmd_n         = 3'd5;
    end
  end

  always_comb begin
    rx_state_d    = rx_state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_d          = rx_q;
    data_d        = data_q;
    dcnt_d        = dcnt_q;
    derr_d        = derr_q;
    resp_valid_d  = resp_valid_q;
    resp_gap_d    = resp_gap_q;
    resp_frames_d = resp_frames_q;
    resp_n_d      = resp_n_q;
    ser_load      = 1'b0;

    // The pending response waits out the gap, then moves into the serializer once it is free.
    if (resp_valid_q && resp_gap_q != 8'd0) resp_gap_d = resp_gap_q - 8'd1;
    if (resp_valid_q && resp_gap_q == 8'd0 && !ser_busy) begin
      ser_load     = 1'b1;
      resp_valid_d = 1'b0;
    end

    unique case (rx_state_q)
      RX_IDLE: begin
        if (!sin_s) begin
          rx_state_d = RX_BITS;
          bit_cnt_d  = '0;
        end
      end
      RX_BITS: begin
        if (bit_cnt_q == 4'd9) begin
          rx_state_d = RX_IDLE;
          if (!sin_s) begin
            derr_d = 1'b1;
          end else if (!rx_q[8]) begin
            data_d = {data_q[55:0], rx_q[7:0]};
            if (dcnt_q != 4'hF) dcnt_d = dcnt_q + 4'd1;
          end else begin
            resp_valid_d  = 1'b1;
            resp_gap_d    = GAP_INIT;
            resp_frames_d = cmd_frames;
            resp_n_d      = cmd_n;
            dcnt_d        = '0;
            derr_d        = 1'b0;
          end
        end else begin
          rx_d      = {rx_q[7:0], sin_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q    <= RX_IDLE;
      bit_cnt_q     <= '0;
      rx_q          <= '0;
      data_q        <= '0;
      dcnt_q        <= '0;
      derr_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_gap_q    <= '0;
      resp_frames_q <= '0;
      resp_n_q      <= '0;
    end else begin
      rx_state_q    <= rx_state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_q          <= rx_d;
      data_q        <= data_d;
      dcnt_q        <= dcnt_d;
      derr_q        <= derr_d;
      resp_valid_q  <= resp_valid_d;
      resp_gap_q    <= resp_gap_d;
      resp_frames_q <= resp_frames_d;
      resp_n_q      <= resp_n_d;
    end
  end

  mtm_alu_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load_i    (ser_load),
    .frames_i  (resp_frames_q),
    .nframes_i (resp_n_q),
    .busy_o    (ser_busy),
    .sout_o    (sout)
  );

endmodule

// File: tb/tb_mtm_alu.sv
// Directed self-checking bench for mtm_alu: drives serial packets, decodes sout, compares to hand-computed values.
module tb_mtm_alu;

  localparam int OUT_GAP = 2;
`ifdef MTM_ALU_SIN_SYNC_EN
  localparam int LAT = OUT_GAP + 3;
`else
  localparam int LAT = OUT_GAP + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sin = 1'b1;
  logic sout;

  int n_total = 0;
  int n_bad   = 0;

  mtm_alu #(.OUT_GAP(OUT_GAP)) dut (
    .clk  (clk),
    .rst  (rst),
    .sin  (sin),
    .sout (sout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_crc4(input logic [67:0] d);
    logic [3:0] c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      logic msb = c[3];
      c = c << 1;
      if (msb ^ d[i]) c = c ^ 4'b0011;
    end
    return c;
  endfunction

  function automatic logic [2:0] ref_crc3(input logic [36:0] d);
    logic [2:0] c = 3'h0;
    for (int i = 36; i >= 0; i--) begin
      logic msb = c[2];
      c = c << 1;
      if (msb ^ d[i]) c = c ^ 3'b011;
    end
    return c;
  endfunction

  task automatic send_frame(input logic ctl, input logic [7:0] payload);
    logic [10:0] f;
    f = {1'b0, ctl, payload, 1'b1};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      sin = f[i];
    end
  endtask

  task automatic send_pkt(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                          input logic flip_crc, input int ndata);
    logic [63:0] bytes;
    logic [3:0]  crc;
    bytes = {b, a};
    crc   = ref_crc4({b, a, 1'b1, op}) ^ (flip_crc ? 4'hF : 4'h0);
    for (int i = 0; i < ndata; i++) send_frame(1'b0, bytes[63-8*i -: 8]);
    send_frame(1'b1, {1'b0, op, crc});
  endtask

  task automatic recv_frame(input int budget, output int waited, output logic [8:0] fr, output logic stop);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (sout !== 1'b0 && waited < budget);
    for (int i = 8; i >= 0; i--) begin
      @(negedge clk);
      fr[i] = sout;
    end
    @(negedge clk);
    stop = sout;
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    int zeros = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (sout !== 1'b1) zeros++;
    end
    check({tag, "_idle"}, zeros, 0);
  endtask

  task automatic expect_result(input string tag, input logic [31:0] exp_c, input logic [3:0] exp_f);
    int          w, gaps;
    logic [8:0]  fr;
    logic        st;
    logic [4:0]  ctls, stops;
    logic [31:0] c;
    logic [7:0]  ctl_pl;
    gaps = 0;
    c    = '0;
    recv_frame(40, w, fr, st);
    check({tag, "_lat"}, w, LAT);
    ctls[4] = fr[8]; stops[4] = st; c[31:24] = fr[7:0];
    for (int k = 3; k >= 1; k--) begin
      recv_frame(2, w, fr, st);
      gaps += w;
      ctls[k] = fr[8]; stops[k] = st; c[8*k-1 -: 8] = fr[7:0];
    end
    recv_frame(2, w, fr, st);
    gaps += w;
    ctls[0] = fr[8]; stops[0] = st; ctl_pl = fr[7:0];
    check({tag, "_ctl"}, ctls, 5'b00001);
    check({tag, "_stop"}, stops, 5'b11111);
    check({tag, "_b2b"}, gaps, 4);
    check({tag, "_c"}, c, exp_c);
    check({tag, "_flags"}, ctl_pl[7:3], {1'b0, exp_f});
    check({tag, "_crc3"}, ctl_pl[2:0], ref_crc3({exp_c, 1'b0, exp_f}));
    watch_idle(tag, 15);
  endtask

  task automatic expect_error(input string tag, input logic [7:0] exp_pl);
    int         w;
    logic [8:0] fr;
    logic       st;
    recv_frame(40, w, fr, st);
    check({tag, "_lat"}, w, LAT);
    check({tag, "_frame"}, {fr, st}, {1'b1, exp_pl, 1'b1});
    watch_idle(tag, 15);
  endtask

  initial begin
    int zeros;

    // Reset held with sin toggling: sout must stay high throughout and after.
    zeros = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sin = ~sin;
      if (sout !== 1'b1) zeros++;
    end
    @(negedge clk);
    rst = 1'b0;
    sin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sout !== 1'b1) zeros++;
    end
    check("reset_sout", zeros, 0);

    send_pkt(32'd2, 32'd1, 3'b100, 1'b0, 8);
    expect_result("add_small", 32'h0000_0003, 4'b0000);

    send_pkt(32'd0, 32'd1, 3'b101, 1'b0, 8);
    expect_result("sub_borrow", 32'hFFFF_FFFF, 4'b1001);

    send_pkt(32'h7FFF_FFFF, 32'd1, 3'b100, 1'b0, 8);
    expect_result("add_ovf", 32'h8000_0000, 4'b0101);

    send_pkt(32'hFFFF_FFFF, 32'd1, 3'b100, 1'b0, 8);
    expect_result("add_carry", 32'h0000_0000, 4'b1010);

    send_pkt(32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b000, 1'b0, 8);
    expect_result("and_zero", 32'h0000_0000, 4'b0010);

    send_pkt(32'd5, 32'd3, 3'b010, 1'b0, 8);
    expect_error("err_op", 8'h93);

    send_pkt(32'd2, 32'd1, 3'b100, 1'b1, 8);
    expect_error("err_crc", 8'hA5);

    send_pkt(32'h1111_2222, 32'h3333_4444, 3'b100, 1'b0, 7);
    expect_error("err_data", 8'hC9);

    send_pkt(32'hFFFF_0000, 32'h00FF_FF00, 3'b000, 1'b0, 8);
    expect_result("and_after_err", 32'h00FF_0000, 4'b0000);

    // Reset in the middle of a packet discards it; the next packet is answered normally.
    for (int i = 0; i < 4; i++) send_frame(1'b0, 8'hA0 + 8'(i));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    watch_idle("mid_reset", 40);

    send_pkt(32'h1234_0000, 32'h0000_5678, 3'b001, 1'b0, 8);
    expect_result("or_after_rst", 32'h1234_5678, 4'b0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
